// File: rtl/n_bit_register_pkg.sv
// Shared constants and the address-width helper for the N-bit register file.
package n_bit_register_pkg;

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_DEPTH = 8;

    // Smallest width that can encode every index 0..depth-1; never below 1.
    function automatic int addr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/n_bit_register_read_port.sv
// One registered read port: entry select, write-first bypass, range check and output register.
module n_bit_register_read_port
    import n_bit_register_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               rd_enable,
    input  logic [AW-1:0]      rd_addr,
    input  logic               wr_enable,
    input  logic [AW-1:0]      wr_addr,
    input  logic [N-1:0]       wr_data,
    input  logic [DEPTH*N-1:0] entries,
    output logic [N-1:0]       rd_data,
    output logic               rd_valid,
    output logic               range_error
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [N-1:0] stored;
    logic [N-1:0] next_data;
    logic         in_range;
    logic         hit;

    always_comb begin
        stored = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                stored = entries[i*N +: N];
            end
        end
    end

    assign in_range = ({1'b0, rd_addr} < DEPTH_V);
    // An in-range read address equal to the write address implies an in-range write.
    assign hit      = wr_enable && (wr_addr == rd_addr);

    always_comb begin
        next_data = '0;
        if (!clear && in_range) begin
            next_data = hit ? wr_data : stored;
        end
    end

    assign range_error = rd_enable && !in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_enable;
            if (rd_enable) begin
                rd_data <= next_data;
            end
        end
    end

endmodule

// File: rtl/n_bit_register_file.sv
// Flip-flop register file with one write port, two independent registered read ports and error flag.
module n_bit_register_file
    import n_bit_register_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int DEPTH   = DEFAULT_DEPTH,
    localparam int AW     = addr_width(DEPTH)
) (
    input  logic          in_clk,
    input  logic          in_res,
    input  logic          in_clear,
    input  logic          in_wr_enable,
    input  logic [AW-1:0] in_wr_addr,
    input  logic [N-1:0]  in_wr_data,
    input  logic          in_rd_enable_a,
    input  logic [AW-1:0] in_rd_addr_a,
    input  logic          in_rd_enable_b,
    input  logic [AW-1:0] in_rd_addr_b,
    output logic [N-1:0]  out_rd_data_a,
    output logic          out_rd_valid_a,
    output logic [N-1:0]  out_rd_data_b,
    output logic          out_rd_valid_b,
    output logic          out_addr_error
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [N-1:0]       mem [DEPTH];
    logic [DEPTH*N-1:0] entries;
    logic               wr_in_range;
    logic               wr_error;
    logic               err_a;
    logic               err_b;

    assign wr_in_range = ({1'b0, in_wr_addr} < DEPTH_V);
    assign wr_error    = in_wr_enable && !wr_in_range;

    always_ff @(posedge in_clk or posedge in_res) begin
        if (in_res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (in_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (in_wr_enable && wr_in_range) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (in_wr_addr == AW'(i)) begin
                    mem[i] <= in_wr_data;
                end
            end
        end
    end

    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*N +: N] = mem[i];
        end
    end

    n_bit_register_read_port #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_port_a (
        .clk         (in_clk),
        .rst         (in_res),
        .clear       (in_clear),
        .rd_enable   (in_rd_enable_a),
        .rd_addr     (in_rd_addr_a),
        .wr_enable   (in_wr_enable),
        .wr_addr     (in_wr_addr),
        .wr_data     (in_wr_data),
        .entries     (entries),
        .rd_data     (out_rd_data_a),
        .rd_valid    (out_rd_valid_a),
        .range_error (err_a)
    );

    n_bit_register_read_port #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_port_b (
        .clk         (in_clk),
        .rst         (in_res),
        .clear       (in_clear),
        .rd_enable   (in_rd_enable_b),
        .rd_addr     (in_rd_addr_b),
        .wr_enable   (in_wr_enable),
        .wr_addr     (in_wr_addr),
        .wr_data     (in_wr_data),
        .entries     (entries),
        .rd_data     (out_rd_data_b),
        .rd_valid    (out_rd_valid_b),
        .range_error (err_b)
    );

    always_ff @(posedge in_clk or posedge in_res) begin
        if (in_res) begin
            out_addr_error <= 1'b0;
        end else begin
            out_addr_error <= wr_error || err_a || err_b;
        end
    end

endmodule
